// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM fade sequencer and PWM benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_ctrl_pkg;

  localparam int DEF_R          = 5;
  localparam int DEF_TIMER_BITS = 8;
  localparam int DEF_STEP_BITS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } fade_state_e;

  // Limit a duty request to 100 % (2^r); anything larger saturates.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input int r);
    logic [31:0] full;
    full = 32'd1 << r;
    if (duty > full) return full;
    return duty;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Step interval timer: counts 0..period while running, tick on the wrap cycle.
// Latency: tick is combinational from the count register, same cycle.
// Backpressure: none; clear overrides run and forces the count to zero.
module pwm_step_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP_BITS = DEF_STEP_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 clear,
  input  logic [STEP_BITS-1:0] period,
  output logic                 tick
);

  logic [STEP_BITS-1:0] cnt_q;
  logic [STEP_BITS-1:0] cnt_d;

  // Wrap detection and next count; the wrap cycle itself is the step event.
  always_comb begin
    tick  = run && !clear && (cnt_q == period);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fade_controller.sv
// Drives Enhanced_PWM enable/final value/duty with one-shot fades or triangle breathing.
// Latency: all outputs registered; start/stop take effect on the following cycle.
// Backpressure: none; start is ignored while busy, stop aborts from any state.
module pwm_fade_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int R          = DEF_R,
  parameter int TIMER_BITS = DEF_TIMER_BITS,
  parameter int STEP_BITS  = DEF_STEP_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [R:0]            duty_lo,
  input  logic [R:0]            duty_hi,
  input  logic [STEP_BITS-1:0]  step_period,
  input  logic [TIMER_BITS-1:0] final_value,
  output logic                  pwm_enable,
  output logic [TIMER_BITS-1:0] pwm_final_value,
  output logic [R:0]            pwm_duty,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = R + 1;

  fade_state_e           state_q, state_d;
  logic [DW-1:0]         duty_q, duty_d;
  logic [DW-1:0]         lo_q, lo_d;
  logic [DW-1:0]         hi_q, hi_d;
  logic [STEP_BITS-1:0]  per_q, per_d;
  logic [TIMER_BITS-1:0] fv_q, fv_d;
  logic                  mode_q, mode_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DW-1:0] lo_c;
  logic [DW-1:0] hi_c;
  logic          tmr_run;
  logic          tmr_clear;
  logic          step_tick;

  assign lo_c = DW'(clamp_duty(32'(duty_lo), R));
  assign hi_c = DW'(clamp_duty(32'(duty_hi), R));

  // The timer only advances while ramping; a stop discards any partial interval.
  assign tmr_run   = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign tmr_clear = stop || !tmr_run;

  pwm_step_timer #(
    .STEP_BITS (STEP_BITS)
  ) u_step_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (tmr_run),
    .clear   (tmr_clear),
    .period  (per_q),
    .tick    (step_tick)
  );

  // Next-state and output decode; latched settings are only captured on an honoured start.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    per_d   = per_q;
    fv_d    = fv_q;
    mode_d  = mode_q;
    en_d    = en_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            lo_d   = lo_c;
            hi_d   = hi_c;
            per_d  = step_period;
            fv_d   = final_value;
            mode_d = mode;
            duty_d = lo_c;
            en_d   = 1'b1;
            if (lo_c < hi_c) begin
              state_d = ST_UP;
            end else begin
              // Empty range: nothing to ramp, a one-shot is complete immediately.
              state_d = ST_HOLD;
              done_d  = !mode;
            end
          end
        end
        ST_UP: begin
          if (step_tick) begin
            duty_d = duty_q + 1'b1;
            if (duty_d == hi_q) begin
              if (mode_q) begin
                state_d = ST_DOWN;
              end else begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_DOWN: begin
          if (step_tick) begin
            duty_d = duty_q - 1'b1;
            if (duty_d == lo_q) begin
              state_d = ST_UP;
              done_d  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      per_q   <= '0;
      fv_q    <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      fv_q    <= fv_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pwm_enable      = en_q;
  assign pwm_final_value = fv_q;
  assign pwm_duty        = duty_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: doc/pwm_fade_controller.md
# pwm_fade_controller

Sequencer that drives the `Enhanced_PWM` control inputs (`enable`, `FINAL_VALUE`, `duty`) to produce timed duty-cycle ramps. It performs either a one-shot fade from a low to a high duty, or a continuous triangle "breathe" between the two. It advances one duty step every programmable number of clocks. It sits between a register/control interface and one `Enhanced_PWM` instance built with the same `R` and `TIMER_BITS`.

## Interface
- `R`, 5, duty resolution; duty ports are R+1 bits and 100 % duty is 2^R.
- `TIMER_BITS`, 8, width of the PWM prescaler final value.
- `STEP_BITS`, 16, width of the step-period counter.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sequence (pulse); honoured only in IDLE.
- `stop`  in  1  abort from any state; has priority over `start`.
- `mode`  in  1  0 = one-shot lo→hi then hold; 1 = breathe lo↔hi until stopped.
- `duty_lo`  in  R+1  start/floor duty; latched at start.
- `duty_hi`  in  R+1  peak duty; latched at start.
- `step_period`  in  STEP_BITS  step interval; one step every `step_period`+1 cycles; latched at start.
- `final_value`  in  TIMER_BITS  PWM prescaler value; latched at start.
- `pwm_enable`  out  1  to PWM `enable`.
- `pwm_final_value`  out  TIMER_BITS  to PWM `FINAL_VALUE`.
- `pwm_duty`  out  R+1  to PWM `duty`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  single-cycle pulse at sequence/cycle completion.

## Operation
- States: IDLE, UP, DOWN, HOLD.
- Clamp rule, applied at latch: any duty value above 2^R becomes 2^R. The clamped results are `lo_c` and `hi_c`.
- IDLE to active:
  - Entered from IDLE on `start` (with `stop` low).
  - Latch `lo_c`, `hi_c`, `step_period`, `final_value`, and `mode`.
  - Load `pwm_duty` = `lo_c` and clear the step timer.
- Entry state after start:
  - If `lo_c` < `hi_c`: go to UP.
  - Otherwise (`lo_c` ≥ `hi_c`): go to HOLD with duty = `lo_c`. Pulse `done` only if mode=0.
- Step timer:
  - Counts 0..`step_period` while in UP or DOWN, then wraps to 0.
  - The wrap cycle is the step event.
  - `step_period`=0 gives a step event every cycle.
- UP, on each step event:
  - duty += 1.
  - When the new duty equals `hi_c`: mode 0 goes to HOLD and pulses `done`; mode 1 goes to DOWN.
- DOWN, on each step event:
  - duty −= 1.
  - When the new duty equals `lo_c`: go to UP and pulse `done` (one breathe cycle complete).
- HOLD: `pwm_enable`=1 and duty is constant. Remain until `stop`.
- `stop` in any state:
  - Next cycle: IDLE, `pwm_enable`=0, `pwm_duty`=0, timer cleared, `done`=0.
  - `stop` and `start` in the same cycle in IDLE: stay IDLE.
- `start` while busy is ignored. Input changes while busy have no effect; the latched copies are used.
- Duty arithmetic is R+1 bits. It never under- or overflows because the value stays within [`lo_c`, `hi_c`] ⊆ [0, 2^R].

## Timing
- Reset (`reset_n`=0 at an edge) has priority over all inputs. Values after reset:
  - state IDLE
  - `pwm_enable`=0, `pwm_duty`=0, `pwm_final_value`=0
  - `busy`=0, `done`=0
  - timer 0
- All outputs are registered.
- `start` sampled at edge k:
  - From cycle k+1: `busy`=1, `pwm_enable`=1, `pwm_duty`=`lo_c`, `pwm_final_value` latched.
- First duty change is visible at cycle k+`step_period`+2. Each later change follows after a further `step_period`+1 cycles.
- `done` is high for exactly one cycle: the first cycle in which the terminal duty value is visible.
- Breathe period = 2·(`hi_c`−`lo_c`)·(`step_period`+1) cycles.
- `stop` sampled at edge k: IDLE outputs from cycle k+1. This holds mid-step as well; the timer is discarded.

## Structure
- Shared package `pwm_ctrl_pkg` holds:
  - the state encoding (IDLE/UP/DOWN/HOLD);
  - a `clamp_duty` function parameterised by R;
  - default constants for R, TIMER_BITS, and STEP_BITS, which shared PWM benches also use.
- Sub-module `pwm_step_timer`:
  - Inputs: `clk`, `reset_n`, `run`, `clear`, `period`.
  - Output: `tick` on the wrap cycle.
  - The FSM instantiates it once.

## Test plan
- Reset, then `start` with mode=0, lo=0, hi=4, step_period=3, final_value=255:
  - `pwm_duty` = 0,1,2,3,4 with 4 cycles per value.
  - `done` pulses in the first cycle duty=4.
  - Duty stays 4 in HOLD; `busy`=1.
- Mode=1, lo=2, hi=5, step_period=0:
  - Duty sequence 2,3,4,5,4,3,2,3,…
  - `done` pulses each time duty returns to 2 (every 6 cycles).
- Clamp and degenerate ranges:
  - hi=63 with R=5 ramps to a 32 peak.
  - lo=10, hi=10, mode=0 goes straight to HOLD with duty 10 and `done` in cycle k+1.
  - The same with mode=1 gives no `done`.
- Stop handling:
  - `stop` asserted mid-UP (duty=3, timer=1) gives IDLE, `pwm_enable`=0, `pwm_duty`=0 next cycle.
  - A subsequent `start` restarts from lo with a fresh timer.
- Input-change rules:
  - `start` pulses and `duty_hi` changes during busy cause no restart or change of the peak.
  - `start`+`stop` together in IDLE leave the block in IDLE.
- Reset mid-DOWN:
  - `reset_n`=0 for one edge gives all outputs at reset values on the next cycle.
